alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the 16-bit combinational ALU: same eight-operation set, generalised to WIDTH bits. Adds saturating ADD/SUB, a registered result with a Z/V/N flag register, and valid/ready flow control on both sides. Shifts optionally run iteratively to save area. It sits between the decode/operand stage and writeback of the WISC datapath.

## Interface
- WIDTH, 16, datapath width; multiple of 8, ≥ 8
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  ALU can accept
- rs  in  WIDTH  operand A
- rt  in  WIDTH  operand B; shifts use rt[SHW-1:0] as amount
- control  in  3  0 ADD, 1 SUB, 2 PADDSB, 3 RED, 4 XOR, 5 SLL, 6 SRA, 7 ROR
- out_valid  out  1  rd/flags hold a result
- out_ready  in  1  consumer takes result
- rd  out  WIDTH  result register
- flags  out  3  {Z, V, N} register
- busy  out  1  high in SHIFT state

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset → IDLE, rd=0, flags=0, out_valid=0, busy=0.
- in_ready = (IDLE) || (DONE && out_ready). An accepted op (in_valid && in_ready) latches rs, rt and control.
- Non-shift op, or any shift with amount 0: result computed and registered on the accept edge → DONE.
- Shift with amount k>0 → SHIFT. The ALU shifts one position per cycle and decrements a counter; on the edge where the counter reaches 0 → DONE.
- DONE: out_valid=1. rd/flags stay stable until out_ready. On out_ready: a simultaneous accept starts the next op, otherwise → IDLE.
- ADD/SUB: two's complement, saturating. Positive overflow → 0111…1, negative overflow → 100…0, and V=1.
- PADDSB: independent signed 4-bit lanes, each saturating to [-8, 7]. No carry between lanes.
- RED: signed sum of all 2·WIDTH/8 bytes of rs and rt, sign-extended to WIDTH, non-saturating.
- XOR: bitwise. SLL: zero fill. SRA: sign fill. ROR: rotate right.
- Flags register updates only when a result is registered:
  - Z is updated by every op.
  - V and N are updated only by ADD/SUB; all other ops hold them.
- Reset asserted in any state, including mid-SHIFT, returns the block to the reset values on the next edge and discards the in-flight op.

## Timing
- Accept at edge T. Result visible with out_valid=1 from T+1 for non-iterative ops, or T+1+k for iterative shifts by k.
- Back-to-back: sustained one result per cycle when out_ready=1 and there are no iterative shifts.
- in_valid while in_ready=0 is ignored. The producer holds its request.

## Configuration
- ALU_ITER_SHIFT_EN defined: shifts take the SHIFT-state path, latency 1+k, one position per cycle.
- ALU_ITER_SHIFT_EN undefined: a single-cycle barrel shifter is used. All ops have latency 1, SHIFT is unreachable and busy is tied 0.

## Structure
- Package alu_pkg:
  - alu_op_e enum for the 3-bit control codes
  - flag bit indices Z_IDX=2, V_IDX=1, N_IDX=0
  - LANE_W=4 and BYTE_W=8
  - state enum alu_state_e
- Sub-module alu_shift_unit: barrel or single-step shift, selected by the macro, instantiated once. The FSM, the saturating arithmetic and the flags live in alu_seq.

## Test plan
- ADD rs=0x7FFF, rt=0x0001 → rd=0x7FFF, flags {Z,V,N}=0b010, out_valid at T+1.
- SUB rs=0x1234, rt=0x1234 → rd=0x0000, Z=1. A following XOR 0x00FF^0x00FF → rd=0x0000, Z=1 with V/N held.
- PADDSB rs=0x7878, rt=0x1111 → rd=0x7979. RED rs=0xFF80, rt=0x8000 → rd=0xFEFF; RED rs=0x0102, rt=0x0304 → 0x000A.
- With ALU_ITER_SHIFT_EN:
  - ROR rs=0x8001, rt=4 → rd=0x1800 at T+5, busy high for 4 cycles.
  - SRA 0x8000 by 15 → 0xFFFF.
  - SLL by 0 → latency 1.
- Backpressure: out_ready=0 for 3 cycles after a result → rd/flags stable and in_ready=0. Then out_ready=1 with in_valid=1 → the next op is accepted in the same cycle.
- rst_n=0 during SHIFT (ROR by 10, cycle 3) → next edge in IDLE, out_valid=0, rd=0, flags=0, and no stale result afterwards.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential WISC ALU (alu_seq).
package alu_pkg;

  localparam int unsigned LANE_W = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned FLAG_W = 3;
  localparam int unsigned Z_IDX  = 2;
  localparam int unsigned V_IDX  = 1;
  localparam int unsigned N_IDX  = 0;

  typedef enum logic [2:0] {
    OP_ADD    = 3'd0,
    OP_SUB    = 3'd1,
    OP_PADDSB = 3'd2,
    OP_RED    = 3'd3,
    OP_XOR    = 3'd4,
    OP_SLL    = 3'd5,
    OP_SRA    = 3'd6,
    OP_ROR    = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift(input alu_op_e op);
    return (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/alu_seq_shift_unit.sv
// Shift datapath for alu_seq: single-cycle barrel shifter by default, or a
// one-position step (applied while amt is non-zero) when ALU_ITER_SHIFT_EN is defined.
module alu_shift_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   amt,
  output logic [WIDTH-1:0] dout
);

`ifdef ALU_ITER_SHIFT_EN
  // A zero count means nothing left to do, so the value passes through.
  always_comb begin
    dout = din;
    if (amt != '0) begin
      case (op)
        OP_SLL:  dout = {din[WIDTH-2:0], 1'b0};
        OP_SRA:  dout = {din[WIDTH-1], din[WIDTH-1:1]};
        OP_ROR:  dout = {din[0], din[WIDTH-1:1]};
        default: dout = din;
      endcase
    end
  end
`else
  always_comb begin
    dout = din;
    case (op)
      OP_SLL:  dout = din << amt;
      OP_SRA:  dout = WIDTH'($signed(din) >>> amt);
      OP_ROR:  dout = WIDTH'({din, din} >> amt);
      default: dout = din;
    endcase
  end
`endif

endmodule

// File: rtl/alu_seq.sv
// Handshaked, registered WIDTH-bit ALU with saturating arithmetic and Z/V/N flags.
// Define ALU_ITER_SHIFT_EN to run shifts one position per cycle in the SHIFT state.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [2:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rd,
  output logic [2:0]       flags,
  output logic             busy
);

  localparam int unsigned N_LANES = WIDTH / LANE_W;
  localparam int unsigned N_BYTES = WIDTH / BYTE_W;
  localparam logic [WIDTH-1:0]  SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]  SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [LANE_W-1:0] LANE_MAX = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] LANE_MIN = {1'b1, {(LANE_W-1){1'b0}}};

  alu_state_e        state_q, state_d;
  logic [WIDTH-1:0]  rd_q, rd_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              out_valid_q, out_valid_d;

  alu_op_e           op_c;
  logic [SHW-1:0]    amt_c;
  logic [WIDTH-1:0]  res_c;
  logic              v_c, n_c;
  logic              accept_c;
  logic              start_shift_c;
  logic              shift_last_c;
  alu_op_e           shift_op_c;
  logic [WIDTH-1:0]  shift_in_c, shift_out_c;
  logic [SHW-1:0]    shift_amt_c;

  assign op_c      = alu_op_e'(control);
  assign amt_c     = rt[SHW-1:0];
  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept_c  = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign rd        = rd_q;
  assign flags     = flags_q;

  alu_shift_unit #(.WIDTH(WIDTH), .SHW(SHW)) u_shift (
    .op   (shift_op_c),
    .din  (shift_in_c),
    .amt  (shift_amt_c),
    .dout (shift_out_c)
  );

`ifdef ALU_ITER_SHIFT_EN
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  alu_op_e          op_q, op_d;
  logic             busy_q, busy_d;

  assign start_shift_c = is_shift(op_c) && (amt_c != '0);
  assign shift_last_c  = (cnt_q == SHW'(1));
  assign shift_op_c    = op_q;
  assign shift_in_c    = acc_q;
  assign shift_amt_c   = cnt_q;
  assign busy          = busy_q;

  // Working value and remaining count for the shift in flight.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    op_d  = op_q;
    if (accept_c && start_shift_c) begin
      acc_d = rs;
      cnt_d = amt_c;
      op_d  = op_c;
    end else if (state_q == S_SHIFT) begin
      acc_d = shift_out_c;
      cnt_d = cnt_q - SHW'(1);
    end
    busy_d = (state_d == S_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      op_q   <= OP_ADD;
      busy_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      busy_q <= busy_d;
    end
  end
`else
  assign start_shift_c = 1'b0;
  assign shift_last_c  = 1'b1;
  assign shift_op_c    = op_c;
  assign shift_in_c    = rs;
  assign shift_amt_c   = amt_c;
  assign busy          = 1'b0;
`endif

  // Single-cycle result for the offered operands.
  always_comb begin
    logic [WIDTH:0]    sum;
    logic [LANE_W:0]   lane;
    logic [WIDTH-1:0]  red;
    sum   = '0;
    lane  = '0;
    red   = '0;
    res_c = '0;
    v_c   = 1'b0;
    n_c   = 1'b0;
    if (op_c == OP_SUB) sum = {rs[WIDTH-1], rs} - {rt[WIDTH-1], rt};
    else                sum = {rs[WIDTH-1], rs} + {rt[WIDTH-1], rt};
    case (op_c)
      OP_ADD, OP_SUB: begin
        if (sum[WIDTH] != sum[WIDTH-1]) begin
          v_c   = 1'b1;
          res_c = sum[WIDTH] ? SAT_MIN : SAT_MAX;
        end else begin
          res_c = sum[WIDTH-1:0];
        end
        n_c = res_c[WIDTH-1];
      end
      OP_PADDSB: begin
        for (int unsigned i = 0; i < N_LANES; i++) begin
          lane = {rs[i*LANE_W + LANE_W - 1], rs[i*LANE_W +: LANE_W]}
               + {rt[i*LANE_W + LANE_W - 1], rt[i*LANE_W +: LANE_W]};
          if (lane[LANE_W] != lane[LANE_W-1])
            res_c[i*LANE_W +: LANE_W] = lane[LANE_W] ? LANE_MIN : LANE_MAX;
          else
            res_c[i*LANE_W +: LANE_W] = lane[LANE_W-1:0];
        end
      end
      OP_RED: begin
        for (int unsigned i = 0; i < N_BYTES; i++) begin
          red = red + WIDTH'($signed(rs[i*BYTE_W +: BYTE_W]))
                    + WIDTH'($signed(rt[i*BYTE_W +: BYTE_W]));
        end
        res_c = red;
      end
      OP_XOR: res_c = rs ^ rt;
`ifdef ALU_ITER_SHIFT_EN
      default: res_c = rs;
`else
      default: res_c = shift_out_c;
`endif
    endcase
  end

  // Next state, result and flags.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    flags_d = flags_q;
    if ((state_q == S_DONE) && out_ready) state_d = S_IDLE;
    if ((state_q == S_SHIFT) && shift_last_c) begin
      state_d        = S_DONE;
      rd_d           = shift_out_c;
      flags_d[Z_IDX] = (shift_out_c == '0);
    end
    if (accept_c) begin
      if (start_shift_c) begin
        state_d = S_SHIFT;
      end else begin
        state_d        = S_DONE;
        rd_d           = res_c;
        flags_d[Z_IDX] = (res_c == '0);
        if ((op_c == OP_ADD) || (op_c == OP_SUB)) begin
          flags_d[V_IDX] = v_c;
          flags_d[N_IDX] = n_c;
        end
      end
    end
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_q        <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: per-cycle comparison against a behavioural
// model, directed literal cases, backpressure, mid-operation reset and random traffic.
module tb_alu_seq;

  localparam int W = 16;
`ifdef ALU_ITER_SHIFT_EN
  localparam bit ITER = 1'b1;
`else
  localparam bit ITER = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] rs = '0;
  logic [W-1:0] rt = '0;
  logic [2:0]   control = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] rd;
  logic [2:0]   flags;
  logic         busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs        (rs),
    .rt        (rt),
    .control   (control),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd        (rd),
    .flags     (flags),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of one operation: {Z,V,N} with V/N held for non-arithmetic ops.
  function automatic void model(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [2:0] fin, output logic [W-1:0] r, output logic [2:0] f);
    int s, va, vb, k;
    k = int'(b[3:0]);
    s = 0;
    r = '0;
    f = fin;
    case (c)
      3'd0, 3'd1: begin
        va = int'($signed(a));
        vb = int'($signed(b));
        s  = (c == 3'd0) ? va + vb : va - vb;
        f[1] = 1'b1;
        if (s > 32767)       r = 16'h7FFF;
        else if (s < -32768) r = 16'h8000;
        else begin
          r    = 16'(s);
          f[1] = 1'b0;
        end
        f[0] = r[15];
      end
      3'd2: begin
        for (int l = 0; l < W / 4; l++) begin
          va = int'($signed(a[4*l +: 4]));
          vb = int'($signed(b[4*l +: 4]));
          s  = va + vb;
          if (s > 7)  s = 7;
          if (s < -8) s = -8;
          r[4*l +: 4] = 4'(s);
        end
      end
      3'd3: begin
        for (int i = 0; i < W / 8; i++)
          s += int'($signed(a[8*i +: 8])) + int'($signed(b[8*i +: 8]));
        r = 16'(s);
      end
      3'd4: r = a ^ b;
      3'd5: r = a << k;
      3'd6: r = 16'(int'($signed(a)) >>> k);
      default: begin
        r = a;
        for (int i = 0; i < k; i++) r = {r[0], r[W-1:1]};
      end
    endcase
    f[2] = (r == '0);
  endfunction

  // Cycle-level expectations: visible result, and cycles left before a pending result appears.
  logic         m_valid = 1'b0;
  logic [W-1:0] m_rd = '0, p_rd = '0;
  logic [2:0]   m_fl = '0, p_fl = '0;
  int           m_wait = 0;

  function automatic bit m_ready(input bit ordy);
    return (m_wait == 0) && (!m_valid || ordy);
  endfunction

  always @(posedge clk) begin
    logic [W-1:0] r;
    logic [2:0]   f;
    bit           acc;
    int           k;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_rd    = '0;
      m_fl    = '0;
      m_wait  = 0;
    end else begin
      acc = in_valid && m_ready(out_ready);
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          m_valid = 1'b1;
          m_rd    = p_rd;
          m_fl    = p_fl;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (acc) begin
        model(control, rs, rt, m_fl, r, f);
        k = int'(rt[3:0]);
        if (ITER && control >= 3'd5 && k > 0) begin
          m_wait  = k;
          m_valid = 1'b0;
          p_rd    = r;
          p_fl    = f;
        end else begin
          m_valid = 1'b1;
          m_rd    = r;
          m_fl    = f;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(m_ready(out_ready)));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("busy", 32'(busy), 32'(ITER && (m_wait > 0)));
      chk("rd", 32'(rd), 32'(m_rd));
      chk("flags", 32'(flags), 32'(m_fl));
    end
  end

  task automatic do_op(input string name, input logic [2:0] c, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp_rd, input logic [2:0] exp_fl,
                       input int exp_lat, input int exp_busy);
    int n, lat, nb;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    control   = c;
    rs        = a;
    rt        = b;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    chk({name, " accept"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    nb  = 0;
    while (!out_valid && lat < 100) begin
      if (busy) nb++;
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " busy cycles"}, 32'(nb), 32'(exp_busy));
    chk({name, " rd"}, 32'(rd), 32'(exp_rd));
    chk({name, " flags"}, 32'(flags), 32'(exp_fl));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    repeat (3) @(posedge clk);
    #1;
    chk("reset rd", 32'(rd), 32'd0);
    chk("reset flags", 32'(flags), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk_en = 1'b1;
    rst_n  = 1'b1;

    do_op("add pos sat", 3'd0, 16'h7FFF, 16'h0001, 16'h7FFF, 3'b010, 1, 0);
    do_op("sub zero",    3'd1, 16'h1234, 16'h1234, 16'h0000, 3'b100, 1, 0);
    do_op("add neg sat", 3'd0, 16'h8000, 16'hFFFF, 16'h8000, 3'b011, 1, 0);
    do_op("xor hold vn", 3'd4, 16'h00FF, 16'h00FF, 16'h0000, 3'b111, 1, 0);
    do_op("paddsb",      3'd2, 16'h7878, 16'h1111, 16'h7979, 3'b011, 1, 0);
    do_op("red neg",     3'd3, 16'hFF80, 16'h8000, 16'hFEFF, 3'b011, 1, 0);
    do_op("red pos",     3'd3, 16'h0102, 16'h0304, 16'h000A, 3'b011, 1, 0);
    do_op("ror 4",       3'd7, 16'h8001, 16'h0004, 16'h1800, 3'b011, ITER ? 5 : 1, ITER ? 4 : 0);
    do_op("sra 15",      3'd6, 16'h8000, 16'h000F, 16'hFFFF, 3'b011, ITER ? 16 : 1, ITER ? 15 : 0);
    do_op("sll 0",       3'd5, 16'h1234, 16'h0010, 16'h1234, 3'b011, 1, 0);
    do_op("sll 3",       3'd5, 16'h0001, 16'h0003, 16'h0008, 3'b011, ITER ? 4 : 1, ITER ? 3 : 0);
    do_op("sub ok",      3'd1, 16'h0005, 16'h0007, 16'hFFFE, 3'b001, 1, 0);

    // Result held under backpressure; a waiting request is taken once out_ready returns.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    control   = 3'd4;
    rs        = 16'hAAAA;
    rt        = 16'h5555;
    @(posedge clk); #1;
    control = 3'd0;
    rs      = 16'h0001;
    rt      = 16'h0002;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp out_valid", 32'(out_valid), 32'd1);
      chk("bp in_ready", 32'(in_ready), 32'd0);
      chk("bp rd", 32'(rd), 32'hFFFF);
      chk("bp flags", 32'(flags), 32'(3'b001));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp next rd", 32'(rd), 32'd3);
    chk("bp next flags", 32'(flags), 32'd0);
    chk("bp next out_valid", 32'(out_valid), 32'd1);

    // Reset in the middle of a long rotate.
    @(posedge clk); #1;
    in_valid = 1'b1;
    control  = 3'd7;
    rs       = 16'h8001;
    rt       = 16'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst rd", 32'(rd), 32'd0);
    chk("rst flags", 32'(flags), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    nv = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) nv++;
    end
    chk("no stale result", 32'(nv), 32'd0);

    // Random traffic with corner operands, random backpressure and rare resets.
    repeat (800) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 3) != 0);
      control  = 3'($urandom_range(0, 7));
      rs       = W'($urandom);
      rt       = W'($urandom);
      case ($urandom_range(0, 7))
        0: rs = 16'h7FFF;
        1: rs = 16'h8000;
        2: rt = 16'h7FFF;
        3: rt = 16'h8000;
        4: rt = rs;
        default: ;
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 299) != 0);
    end
    @(posedge clk); #1;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
